// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write/read-side controllers.
package fifo_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int CNT_WIDTH          = $clog2(DEFAULT_FIFO_DEPTH + 1);

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [CNT_WIDTH-1:0]          cnt_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wr_state_e;
endpackage

// File: rtl/fifo_occ_tracker.sv
// Mirror of FIFO occupancy: up on a landed write, down on a read that has data.
module fifo_occ_tracker #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_ok;

    // A read on an empty FIFO is an underflow and must not move the mirror.
    assign dec_ok = dec && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec_ok) begin
            if (cnt_q != CW'(DEPTH))
                cnt_d = cnt_q + 1'b1;
        end else if (dec_ok && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

    a_no_saturate: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc && !dec_ok && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side front end for fifo_dut: valid/ready intake, registered wr_n/din,
// occupancy mirror so the FIFO is never overrun, sticky overflow flag.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int INIT_CYCLES = 2,
    parameter int LW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wr_n,
    output logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_n_mon,
    input  logic                  over_flow_mon,
    input  logic                  clr_err,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  err_ovf
);
    wr_state_e             state_q, state_d;
    logic [3:0]            init_cnt_q, init_cnt_d;
    logic                  wr_n_q, wr_n_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  err_q, err_d;
    logic [LW-1:0]         fifo_cnt;
    logic [LW:0]           reserved;
    logic                  accept;

    fifo_occ_tracker #(
        .DEPTH (FIFO_DEPTH),
        .CW    (LW)
    ) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!wr_n_q),
        .dec   (!rd_n_mon),
        .cnt   (fifo_cnt)
    );

    // One extra bit so the in-flight beat can never wrap the sum.
    assign reserved = {1'b0, fifo_cnt} + {{LW{1'b0}}, pending_q};
    assign s_ready  = (state_q == RUN) && (reserved < (LW+1)'(FIFO_DEPTH));
    assign accept   = s_valid && s_ready;
    assign level    = reserved[LW-1:0];
    assign full     = (reserved == (LW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 4'd1;
                if (init_cnt_q == 4'(INIT_CYCLES - 1))
                    state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        wr_n_d    = !accept;
        pending_d = accept;
        din_d     = accept ? s_data : din_q;
        // A new overflow report wins over a clear in the same cycle.
        err_d     = over_flow_mon | (err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            wr_n_q     <= 1'b1;
            pending_q  <= 1'b0;
            din_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_n_q     <= wr_n_d;
            pending_q  <= pending_d;
            din_q      <= din_d;
            err_q      <= err_d;
        end
    end

    assign wr_n    = wr_n_q;
    assign din     = din_q;
    assign err_ovf = err_q;

    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(!wr_n_q && fifo_cnt == LW'(FIFO_DEPTH)));
    a_din_only_on_accept: assert property (@(posedge clk) disable iff (!rst_n)
        !accept |=> $stable(din_q));
    a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
        reserved <= (LW+1)'(FIFO_DEPTH));
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed plan plus randomized traffic against a queue-level occupancy model.
module tb_fifo_wr_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int INITC = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          wr_n;
    logic [DW-1:0] din;
    logic          rd_n_mon = 1'b1;
    logic          over_flow_mon = 1'b0;
    logic          clr_err = 1'b0;
    logic [LW-1:0] level;
    logic          full;
    logic          err_ovf;

    fifo_wr_ctrl #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .INIT_CYCLES (INITC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .wr_n          (wr_n),
        .din           (din),
        .rd_n_mon      (rd_n_mon),
        .over_flow_mon (over_flow_mon),
        .clr_err       (clr_err),
        .level         (level),
        .full          (full),
        .err_ovf       (err_ovf)
    );

    always #5 clk = ~clk;

    // Model: contents of the FIFO as a queue, plus the beat in flight.
    logic [DW-1:0] fifo_q[$];
    int            m_wr;
    logic [DW-1:0] m_din;
    int            m_init_left;
    int            m_err;
    int            wr_pulses;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_ready();
        return (m_init_left == 0 && (fifo_q.size() + m_wr) < DEPTH) ? 1 : 0;
    endfunction

    // Called at a falling edge with inputs already applied; returns at the next one.
    task automatic cycle();
        int acc;
        int lvl;
        lvl = fifo_q.size() + m_wr;
        chk("s_ready", s_ready, m_ready());
        chk("wr_n", wr_n, (m_wr != 0) ? 0 : 1);
        chk("din", din, m_din);
        chk("level", level, lvl);
        chk("full", full, (lvl == DEPTH) ? 1 : 0);
        chk("err_ovf", err_ovf, m_err);
        if (wr_n === 1'b0) wr_pulses++;
        acc = (s_valid && m_ready() != 0) ? 1 : 0;
        @(posedge clk);
        if (!rd_n_mon && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (m_wr != 0) fifo_q.push_back(m_din);
        m_wr = acc;
        if (acc != 0) m_din = s_data;
        if (m_init_left > 0) m_init_left--;
        if (over_flow_mon) m_err = 1;
        else if (clr_err) m_err = 0;
        @(negedge clk);
        $display("cyc t=%0t v=%0b d=%02h rd_n=%0b -> rdy=%0b wr_n=%0b din=%02h lvl=%0d",
                 $time, s_valid, s_data, rd_n_mon, s_ready, wr_n, din, level);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_n", wr_n, 1);
        chk("rst_level", level, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_full", full, 0);
        chk("rst_din", din, 0);
        chk("rst_err", err_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fifo_q.delete();
        m_wr = 0;
        m_din = '0;
        m_init_left = INITC;
        m_err = 0;
    endtask

    task automatic stream(input int n, input logic [DW-1:0] first);
        int got;
        int guard;
        got = 0;
        guard = 0;
        s_valid = 1'b1;
        s_data = first;
        while (got < n && guard < 200) begin
            int a;
            a = m_ready();
            cycle();
            if (a != 0) begin
                got++;
                s_data = first + DW'(got);
            end
            guard++;
        end
        chk("stream_done", got, n);
    endtask

    initial begin
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // 1: INIT hold-off then one-cycle write latency
        s_valid = 1'b1;
        s_data  = 8'hA5;
        chk("t1_init0", s_ready, 0);
        cycle();
        chk("t1_init1", s_ready, 0);
        cycle();
        chk("t1_ready", s_ready, 1);
        cycle();
        s_valid = 1'b0;
        chk("t1_wr_n", wr_n, 0);
        chk("t1_din", din, 8'hA5);
        chk("t1_level", level, 1);
        cycle();

        // 2: fill to depth, 17th beat held
        do_reset();
        repeat (INITC) cycle();
        wr_pulses = 0;
        stream(DEPTH, 8'h00);
        chk("t2_full", full, 1);
        chk("t2_ready", s_ready, 0);
        chk("t2_level", level, DEPTH);
        repeat (2) cycle();
        chk("t2_pulses", wr_pulses, DEPTH);
        chk("t2_err", err_ovf, 0);

        // 3: single read from full; bubble then held beat accepted
        rd_n_mon = 1'b0;
        chk("t3_bubble", s_ready, 0);
        cycle();
        rd_n_mon = 1'b1;
        chk("t3_freed", s_ready, 1);
        cycle();
        s_valid = 1'b0;
        chk("t3_level", level, DEPTH);
        chk("t3_din", din, 8'h10);

        // 4: drain, underflow reads, write landing with an empty read
        rd_n_mon = 1'b0;
        repeat (DEPTH + 3) cycle();
        chk("t4_empty", level, 0);
        repeat (3) cycle();
        chk("t4_underflow", level, 0);
        s_valid = 1'b1;
        s_data  = 8'h3C;
        cycle();
        s_valid = 1'b0;
        cycle();
        rd_n_mon = 1'b1;
        chk("t4_landed", level, 1);
        cycle();

        // 5: sticky overflow error, set beats clear
        over_flow_mon = 1'b1;
        cycle();
        over_flow_mon = 1'b0;
        chk("t5_set", err_ovf, 1);
        cycle();
        chk("t5_sticky", err_ovf, 1);
        over_flow_mon = 1'b1;
        clr_err = 1'b1;
        cycle();
        over_flow_mon = 1'b0;
        chk("t5_set_wins", err_ovf, 1);
        cycle();
        clr_err = 1'b0;
        chk("t5_cleared", err_ovf, 0);

        // 6: reset with a beat in flight
        do_reset();
        repeat (INITC) cycle();
        stream(9, 8'h40);
        s_valid = 1'b0;
        chk("t6_level", level, 9);
        chk("t6_pending", wr_n, 0);
        do_reset();
        chk("t6_init0", s_ready, 0);
        cycle();
        chk("t6_init1", s_ready, 0);
        cycle();
        chk("t6_run", s_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            s_valid       = ($urandom_range(0, 99) < 70);
            s_data        = DW'($urandom);
            rd_n_mon      = !($urandom_range(0, 99) < 40);
            over_flow_mon = ($urandom_range(0, 99) < 2);
            clr_err       = ($urandom_range(0, 99) < 5);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Upstream write-side stage for fifo_dut.
- Accepts a valid/ready stream from a producer and drives the FIFO's active-low wr_n and din.
- Keeps a mirror of FIFO occupancy by observing the FIFO's rd_n, so it never causes over_flow.
- Shares clk/rst_n with fifo_dut; reports live level, full, and a sticky overflow error if the FIFO ever flags one.

Parameters:
- DATA_WIDTH, 8, width of din/s_data; must match fifo_dut.
- FIFO_DEPTH, 16, number of entries in fifo_dut; must be at least 2.
- INIT_CYCLES, 2, cycles after reset release during which s_ready is held low; range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset; same net as fifo_dut rst_n.
- s_valid  input  1  producer has a beat.
- s_data  input  DATA_WIDTH  producer data.
- s_ready  output  1  block accepts a beat this cycle.
- wr_n  output  1  active-low FIFO write enable, registered.
- din  output  DATA_WIDTH  FIFO write data, registered.
- rd_n_mon  input  1  copy of the FIFO's rd_n; used for occupancy tracking only.
- over_flow_mon  input  1  the FIFO's over_flow flag.
- clr_err  input  1  synchronous clear of err_ovf.
- level  output  $clog2(FIFO_DEPTH+1)  reserved occupancy, fifo_cnt + pending.
- full  output  1  level == FIFO_DEPTH.
- err_ovf  output  1  sticky overflow error.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=INIT, init_cnt=0, fifo_cnt=0, pending=0.
  - wr_n=1, din=0, err_ovf=0.
  - s_ready=0, level=0, full=0.
- FSM:
  - INIT: init_cnt increments each cycle; move to RUN when init_cnt==INIT_CYCLES-1. s_ready=0 in INIT.
  - RUN: normal operation. The FSM leaves RUN only through reset.
- Acceptance:
  - A beat is accepted when s_valid && s_ready.
  - s_ready is combinational from registers only: (state==RUN) && (fifo_cnt + pending < FIFO_DEPTH). It never depends on s_valid.
- Write pipeline:
  - Latency is exactly 1 cycle. On the edge where a beat is accepted: wr_n<=0, din<=s_data, pending<=1.
  - With no acceptance: wr_n<=1, pending<=0, and din holds its value.
  - Back-to-back beats produce consecutive wr_n=0 cycles.
- fifo_cnt update, per edge:
  - +1 if wr_n==0.
  - -1 if rd_n_mon==0 && fifo_cnt>0.
  - Both conditions: no change.
  - A read while fifo_cnt==0 is an underflow and does not decrement. This holds even if pending==1, because that beat is not yet in the FIFO.
- Freed space is visible one cycle after the read. When full with a simultaneous read, s_ready stays low that cycle; this conservative bubble is required.
- Arithmetic:
  - fifo_cnt + pending is evaluated at $clog2(FIFO_DEPTH+1)+1 bits, so there is no wrap.
  - fifo_cnt saturates at FIFO_DEPTH. Reaching the saturation condition is a design bug; an assertion covers it.
- err_ovf:
  - Set on any edge where over_flow_mon==1.
  - Cleared by clr_err==1.
  - Set has priority over clear in the same cycle.
- Reset mid-operation:
  - The pending beat is dropped and wr_n returns to 1 immediately (asynchronously).
  - Counters clear; fifo_dut clears on the same reset.
  - After release the FSM runs INIT again.
- Assertions:
  - Never wr_n==0 while fifo_cnt==FIFO_DEPTH.
  - s_data is not sampled unless accepted.
  - level <= FIFO_DEPTH.

Decomposition:
- Package fifo_pkg:
  - DATA_WIDTH and FIFO_DEPTH defaults.
  - typedef data_t logic [DATA_WIDTH-1:0].
  - typedef cnt_t for level width.
  - enum wr_state_e {INIT, RUN}.
- One sub-module: fifo_occ_tracker, containing the fifo_cnt up/down counter with saturation and the underflow-guarded decrement. It is reused later by a read-side controller.

Test Plan:
1. Release reset, hold s_valid=1 with s_data=8'hA5 → s_ready=0 for 2 cycles, then beat accepted; wr_n=0 with din=8'hA5 exactly 1 cycle after acceptance; level=1.
2. Stream 16 beats 8'h00..8'h0F with rd_n_mon=1 → 16 write pulses; full=1, s_ready=0 after the 16th acceptance; a 17th beat is held; over_flow_mon never asserted; err_ovf=0.
3. From full, pulse rd_n_mon=0 for 1 cycle → s_ready=0 on the read cycle, 1 on the next; the held beat is accepted; level returns to 16.
4. From empty, rd_n_mon=0 for 3 cycles → fifo_cnt stays 0, level=0. Simultaneous accept with read at fifo_cnt=0: fifo_cnt=1 after the write lands.
5. Force over_flow_mon=1 for 1 cycle → err_ovf=1 and stays; clr_err=1 with over_flow_mon=1 keeps it at 1; clr_err=1 alone clears it.
6. Assert rst_n=0 mid-stream with level=9 and pending=1 → wr_n=1 immediately; level=0, s_ready=0; INIT replays after release.
